// File: rtl/shader_fetch_decode_if.sv
// ----------------------------------------------------------------------------
// shader_fetch_decode_if
//   Bundles the two buses of the shader fetch/decode stage:
//     - instruction-memory read port (address, read strobe, read data)
//     - issue handshake to the operand-read/ALU stage (valid/ready + fields)
//   master : the fetch/decode stage
//   slave  : the environment (instruction memory + downstream ALU stage)
// ----------------------------------------------------------------------------
interface shader_fetch_decode_if #(
    parameter int PCW = 8
);
    // Instruction memory read port; data returns one cycle after imem_rd_en.
    logic [PCW-1:0] imem_addr;
    logic           imem_rd_en;
    logic [31:0]    imem_rdata;

    // Issue port toward the operand-read/ALU stage.
    logic           iss_valid;
    logic           iss_ready;
    logic [4:0]     iss_opcode;
    logic [3:0]     iss_rd;
    logic [3:0]     iss_rs0;
    logic [3:0]     iss_rs1;
    logic [10:0]    iss_immd;
    logic [PCW-1:0] iss_pc;

    modport master (
        output imem_addr,
        output imem_rd_en,
        input  imem_rdata,
        output iss_valid,
        input  iss_ready,
        output iss_opcode,
        output iss_rd,
        output iss_rs0,
        output iss_rs1,
        output iss_immd,
        output iss_pc
    );

    modport slave (
        input  imem_addr,
        input  imem_rd_en,
        output imem_rdata,
        input  iss_valid,
        output iss_ready,
        input  iss_opcode,
        input  iss_rd,
        input  iss_rs0,
        input  iss_rs1,
        input  iss_immd,
        input  iss_pc
    );
endinterface

// File: rtl/shader_fetch_decode.sv
// ----------------------------------------------------------------------------
// shader_fetch_decode
//   Instruction fetch/decode stage in front of the shader ALU. Walks a program
//   held in a synchronous-read instruction memory starting at start_pc,
//   decodes each 32-bit word and offers it downstream over valid/ready.
//   A program ends on HALT (never issued) or when the instruction at the last
//   memory address has been accepted (sticky overrun flag).
//
//   Instruction word:
//     [31:27] opcode  (0..14 legal, 5'h1F = HALT, 15..30 issued as NOP)
//     [26:23] rd   [22:19] rs0   [18:15] rs1   [14:11] reserved   [10:0] immd
//
//   Optional build macro:
//     SHADER_FETCH_STATS_EN - adds saturating issued_cnt / stall_cnt outputs.
//
//   Reset is synchronous and active-high.
// ----------------------------------------------------------------------------
module shader_fetch_decode #(
    parameter int  IMEM_DEPTH = 256,
    // Register indices occupy 4-bit fields in the instruction word, so
    // NUM_REGS may be at most 16; narrower indices take the low field bits.
    parameter int  NUM_REGS   = 16,
    localparam int PCW        = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PCW-1:0]       start_pc,
    shader_fetch_decode_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
`ifdef SHADER_FETCH_STATS_EN
    ,
    output logic [31:0]          issued_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int             RIW      = $clog2(NUM_REGS);
    localparam logic [4:0]     OP_HALT  = 5'h1F;
    localparam logic [4:0]     OP_LAST  = 5'd14;   // OP_MATMUL, last legal opcode
    localparam logic [4:0]     OP_NOP   = 5'd0;
    localparam logic [PCW-1:0] PC_LAST  = PCW'(IMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE
    } state_t;

    typedef struct packed {
        logic [4:0]     opcode;
        logic [RIW-1:0] rd;
        logic [RIW-1:0] rs0;
        logic [RIW-1:0] rs1;
        logic [10:0]    immd;
    } decoded_t;

    state_t         state;
    logic [PCW-1:0] pc;
    decoded_t       dec;
    logic           is_halt;

    // Combinational decode of the word returned by the instruction memory.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        dec     = '0;
        is_halt = 1'b0;

        dec.rd   = bus.imem_rdata[23 +: RIW];
        dec.rs0  = bus.imem_rdata[19 +: RIW];
        dec.rs1  = bus.imem_rdata[15 +: RIW];
        dec.immd = bus.imem_rdata[10:0];

        if (bus.imem_rdata[31:27] == OP_HALT) begin
            is_halt = 1'b1;
        end else if (bus.imem_rdata[31:27] > OP_LAST) begin
            // Illegal opcodes travel downstream as NOP with fields intact.
            dec.opcode = OP_NOP;
        end else begin
            dec.opcode = bus.imem_rdata[31:27];
        end
    end

    // Control FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state is written with non-blocking assignments
            // so every register samples pre-edge values regardless of order.
            state          <= S_IDLE;
            pc             <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overrun        <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_rd_en <= 1'b0;
            bus.iss_valid  <= 1'b0;
            bus.iss_opcode <= '0;
            bus.iss_rd     <= '0;
            bus.iss_rs0    <= '0;
            bus.iss_rs1    <= '0;
            bus.iss_immd   <= '0;
            bus.iss_pc     <= '0;
        end else begin
            done <= 1'b0;

            case (state)
                S_IDLE: begin
                    // start is only honoured here, so a start while busy is dropped.
                    if (start) begin
                        pc             <= start_pc;
                        overrun        <= 1'b0;
                        busy           <= 1'b1;
                        bus.imem_addr  <= start_pc;
                        bus.imem_rd_en <= 1'b1;
                        state          <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    // The read strobe was raised on entry; memory data lands
                    // on imem_rdata during DECODE.
                    bus.imem_rd_en <= 1'b0;
                    state          <= S_DECODE;
                end

                S_DECODE: begin
                    if (is_halt) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        bus.iss_opcode <= dec.opcode;
                        bus.iss_rd     <= 4'(dec.rd);
                        bus.iss_rs0    <= 4'(dec.rs0);
                        bus.iss_rs1    <= 4'(dec.rs1);
                        bus.iss_immd   <= dec.immd;
                        bus.iss_pc     <= pc;
                        bus.iss_valid  <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Fields are only written in DECODE, so they hold while stalled.
                    if (bus.iss_ready) begin
                        bus.iss_valid <= 1'b0;
                        // End of memory is checked before the increment, so
                        // the PC never wraps back to zero.
                        if (pc == PC_LAST) begin
                            overrun <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            pc             <= pc + 1'b1;
                            bus.imem_addr  <= pc + 1'b1;
                            bus.imem_rd_en <= 1'b1;
                            state          <= S_FETCH;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SHADER_FETCH_STATS_EN
    // Saturating issue and stall counters, restarted by an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else if (state == S_IDLE && start) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else if (state == S_ISSUE) begin
            if (bus.iss_ready && issued_cnt != 32'hFFFF_FFFF) begin
                issued_cnt <= issued_cnt + 1'b1;
            end
            if (!bus.iss_ready && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shader_fetch_decode.sv
// ----------------------------------------------------------------------------
// tb_shader_fetch_decode
//   Directed bench for shader_fetch_decode. Two instances: a default-depth one
//   (256 words) for the main programs and a 4-word one for the end-of-memory
//   overrun case. Each has a small synchronous-read memory model.
//   Stats outputs are checked when SHADER_FETCH_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_shader_fetch_decode;

    localparam logic [4:0] HALT = 5'h1F;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] start_pc0;
    logic [1:0] start_pc1;
    logic       busy0, done0, overrun0;
    logic       busy1, done1, overrun1;
`ifdef SHADER_FETCH_STATS_EN
    logic [31:0] issued0, stall0, issued1, stall1;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int hs0 = 0;
    int hs1 = 0;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [4];

    shader_fetch_decode_if #(.PCW(8)) bus0 ();
    shader_fetch_decode_if #(.PCW(2)) bus1 ();

    shader_fetch_decode #(.IMEM_DEPTH(256), .NUM_REGS(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .start_pc   (start_pc0),
        .bus        (bus0),
        .busy       (busy0),
        .done       (done0),
        .overrun    (overrun0)
`ifdef SHADER_FETCH_STATS_EN
        ,
        .issued_cnt (issued0),
        .stall_cnt  (stall0)
`endif
    );

    shader_fetch_decode #(.IMEM_DEPTH(4), .NUM_REGS(16)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .start_pc   (start_pc1),
        .bus        (bus1),
        .busy       (busy1),
        .done       (done1),
        .overrun    (overrun1)
`ifdef SHADER_FETCH_STATS_EN
        ,
        .issued_cnt (issued1),
        .stall_cnt  (stall1)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memories.
    always @(posedge clk) begin
        if (bus0.imem_rd_en) bus0.imem_rdata <= mem0[bus0.imem_addr];
        if (bus1.imem_rd_en) bus1.imem_rdata <= mem1[bus1.imem_addr];
    end

    // Handshake counters.
    always @(posedge clk) begin
        if (!rst && bus0.iss_valid && bus0.iss_ready) hs0 <= hs0 + 1;
        if (!rst && bus1.iss_valid && bus1.iss_ready) hs1 <= hs1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // done and busy must never be high together.
    always @(negedge clk) begin
        if (!rst) begin
            check("done_busy0", 32'(done0 & busy0), 32'd0);
            check("done_busy1", 32'(done1 & busy1), 32'd0);
        end
    end

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs0, input logic [3:0] rs1,
                                        input logic [10:0] immd, input logic [3:0] rsv);
        return {op, rd, rs0, rs1, rsv, immd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel, input logic [7:0] pc);
        if (sel) begin
            start1    = 1'b1;
            start_pc1 = pc[1:0];
        end else begin
            start0    = 1'b1;
            start_pc0 = pc;
        end
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, input string tag, output int n);
        n = 0;
        while (!(sel ? bus1.iss_valid : bus0.iss_valid) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(sel ? bus1.iss_valid : bus0.iss_valid), 32'd1);
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n = 0;
        while (!(sel ? done1 : done0) && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(sel ? done1 : done0), 32'd1);
    endtask

    task automatic check_issue(input string tag, input logic [4:0] op, input logic [3:0] rd,
                               input logic [3:0] rs0, input logic [3:0] rs1,
                               input logic [10:0] immd, input logic [7:0] pc);
        check({tag, "_opcode"}, 32'(bus0.iss_opcode), 32'(op));
        check({tag, "_rd"},     32'(bus0.iss_rd),     32'(rd));
        check({tag, "_rs0"},    32'(bus0.iss_rs0),    32'(rs0));
        check({tag, "_rs1"},    32'(bus0.iss_rs1),    32'(rs1));
        check({tag, "_immd"},   32'(bus0.iss_immd),   32'(immd));
        check({tag, "_pc"},     32'(bus0.iss_pc),     32'(pc));
    endtask

    initial begin
        int n;
        int hs_base;

        for (int i = 0; i < 256; i++) mem0[i] = '0;
        for (int i = 0; i < 4; i++) mem1[i] = '0;
        bus0.imem_rdata = '0;
        bus1.imem_rdata = '0;
        bus0.iss_ready  = 1'b1;
        bus1.iss_ready  = 1'b1;
        start0 = 1'b0;  start1 = 1'b0;
        start_pc0 = '0; start_pc1 = '0;

        // ---------------- reset values ----------------
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        check("rst_busy",    32'(busy0),           32'd0);
        check("rst_done",    32'(done0),           32'd0);
        check("rst_valid",   32'(bus0.iss_valid),  32'd0);
        check("rst_pc",      32'(bus0.iss_pc),     32'd0);
        check("rst_overrun", 32'(overrun0),        32'd0);
        check("rst_rd_en",   32'(bus0.imem_rd_en), 32'd0);
        check("rst_opcode",  32'(bus0.iss_opcode), 32'd0);

        // ---------------- ADD then HALT ----------------
        mem0[0] = 32'h0989_0000;                 // ADD rd=3 rs0=1 rs1=2
        mem0[1] = enc(HALT, 4'd0, 4'd0, 4'd0, 11'd0, 4'd0);
        hs_base = hs0;
        pulse_start(1'b0, 8'd0);
        check("t1_rd_en", 32'(bus0.imem_rd_en), 32'd1);
        check("t1_addr",  32'(bus0.imem_addr),  32'd0);
        check("t1_busy",  32'(busy0),           32'd1);
        wait_valid(1'b0, "t1", n);
        // FETCH, DECODE, then valid in the third cycle after the start edge.
        check("t1_latency", 32'(n), 32'd2);
        check_issue("t1", 5'd1, 4'd3, 4'd1, 4'd2, 11'd0, 8'd0);
        tick();
        wait_done(1'b0, "t1");
        check("t1_busy_at_done", 32'(busy0), 32'd0);
        tick();
        check("t1_done_pulse", 32'(done0), 32'd0);
        check("t1_busy_after", 32'(busy0), 32'd0);
        check("t1_issues", 32'(hs0 - hs_base), 32'd1);

        // ---------------- STORE at imem[5] ----------------
        mem0[5] = enc(5'd12, 4'd7, 4'd4, 4'd9, 11'h3A5, 4'd0);
        mem0[6] = enc(HALT, 4'd0, 4'd0, 4'd0, 11'd0, 4'd0);
        pulse_start(1'b0, 8'd5);
        wait_valid(1'b0, "t2", n);
        check_issue("t2", 5'd12, 4'd7, 4'd4, 4'd9, 11'h3A5, 8'd5);
        tick();
        wait_done(1'b0, "t2");

        // ---------------- backpressure for 4 cycles ----------------
        mem0[10] = enc(5'd3, 4'd1, 4'd2, 4'd3, 11'h7FF, 4'd0);
        mem0[11] = enc(HALT, 4'd0, 4'd0, 4'd0, 11'd0, 4'd0);
        hs_base = hs0;
        bus0.iss_ready = 1'b0;
        pulse_start(1'b0, 8'd10);
        wait_valid(1'b0, "t3", n);
        for (int c = 0; c < 4; c++) begin
            check("t3_hold_valid", 32'(bus0.iss_valid), 32'd1);
            check_issue("t3_hold", 5'd3, 4'd1, 4'd2, 4'd3, 11'h7FF, 8'd10);
            tick();
        end
        bus0.iss_ready = 1'b1;
        tick();
        check("t3_valid_dropped", 32'(bus0.iss_valid), 32'd0);
        wait_done(1'b0, "t3");
        check("t3_issues", 32'(hs0 - hs_base), 32'd1);
`ifdef SHADER_FETCH_STATS_EN
        check("t3_stall_cnt",  stall0,  32'd4);
        check("t3_issued_cnt", issued0, 32'd1);
`endif

        // ---------------- legal/illegal opcode boundaries ----------------
        mem0[0] = enc(5'd20, 4'd5, 4'd6, 4'd7, 11'h123, 4'hA);
        mem0[1] = enc(5'd14, 4'd15, 4'd0, 4'd8, 11'h7FF, 4'd0);
        mem0[2] = enc(5'd15, 4'd1, 4'd2, 4'd3, 11'h001, 4'd0);
        mem0[3] = enc(HALT, 4'd9, 4'd9, 4'd9, 11'h0AA, 4'd0);
        hs_base = hs0;
        pulse_start(1'b0, 8'd0);
        wait_valid(1'b0, "t4a", n);
        check_issue("t4a", 5'd0, 4'd5, 4'd6, 4'd7, 11'h123, 8'd0);
        tick();
        wait_valid(1'b0, "t4b", n);
        check_issue("t4b", 5'd14, 4'd15, 4'd0, 4'd8, 11'h7FF, 8'd1);
        tick();
        wait_valid(1'b0, "t4c", n);
        check_issue("t4c", 5'd0, 4'd1, 4'd2, 4'd3, 11'h001, 8'd2);
        tick();
        wait_done(1'b0, "t4");
        check("t4_issues",  32'(hs0 - hs_base), 32'd3);
        check("t4_overrun", 32'(overrun0), 32'd0);

        // ---------------- run off end of a 4-word memory ----------------
        mem1[2] = enc(5'd0, 4'd0, 4'd0, 4'd0, 11'd0, 4'd0);
        mem1[3] = enc(5'd0, 4'd1, 4'd1, 4'd1, 11'd0, 4'd0);
        hs_base = hs1;
        pulse_start(1'b1, 8'd2);
        wait_done(1'b1, "t5");
        check("t5_overrun_at_done", 32'(overrun1), 32'd1);
        check("t5_issues", 32'(hs1 - hs_base), 32'd2);
        tick();
        check("t5_overrun_sticky", 32'(overrun1), 32'd1);
        check("t5_busy_after", 32'(busy1), 32'd0);
        mem1[2] = enc(HALT, 4'd0, 4'd0, 4'd0, 11'd0, 4'd0);
        pulse_start(1'b1, 8'd2);
        check("t5_overrun_cleared", 32'(overrun1), 32'd0);
        wait_done(1'b1, "t5b");
        check("t5b_overrun", 32'(overrun1), 32'd0);

        // ---------------- start while busy, then reset in ISSUE ----------------
        mem0[20] = enc(5'd2, 4'd4, 4'd5, 4'd6, 11'h055, 4'd0);
        bus0.iss_ready = 1'b0;
        pulse_start(1'b0, 8'd20);
        wait_valid(1'b0, "t6", n);
        pulse_start(1'b0, 8'd0);
        check("t6_ignored_valid", 32'(bus0.iss_valid), 32'd1);
        check("t6_ignored_pc",    32'(bus0.iss_pc),    32'd20);
        check("t6_ignored_busy",  32'(busy0),          32'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_valid",  32'(bus0.iss_valid),  32'd0);
        check("t6_rst_busy",   32'(busy0),           32'd0);
        check("t6_rst_pc",     32'(bus0.iss_pc),     32'd0);
        check("t6_rst_opcode", 32'(bus0.iss_opcode), 32'd0);
        check("t6_rst_rd_en",  32'(bus0.imem_rd_en), 32'd0);
`ifdef SHADER_FETCH_STATS_EN
        check("t6_rst_stall_cnt", stall0, 32'd0);
`endif
        rst = 1'b0;
        bus0.iss_ready = 1'b1;
        tick();
        check("t6_idle_valid", 32'(bus0.iss_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
